// File: rtl/ddr_line_burst_reader.sv
// ddr_line_burst_reader: IPIF master read engine that fetches one DDR burst per fill request
// and streams the returned beats into the HDMI line FIFO. Option macro: DDR_BYTE_SWAP_EN.
module ddr_line_burst_reader #(
  parameter int unsigned BURST_WORDS = 64,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              Bus2IP_Clk,
  input  logic              Bus2IP_Resetn,
  input  logic              go_fill_fifo,
  input  logic [ADDR_W-1:0] ddr_addr_to_read,
  output logic              IP2Bus_MstRd_Req,
  output logic [ADDR_W-1:0] IP2Bus_Mst_Addr,
  output logic [11:0]       IP2Bus_Mst_Length,
  input  logic              Bus2IP_Mst_CmdAck,
  input  logic              Bus2IP_Mst_Cmplt,
  input  logic              Bus2IP_Mst_Error,
  input  logic [31:0]       Bus2IP_MstRd_d,
  input  logic              Bus2IP_MstRd_src_rdy_n,
  output logic              IP2Bus_MstRd_dst_rdy_n,
  input  logic              fifo_full,
  output logic              fifo_wr_en,
  output logic [31:0]       fifo_wr_data,
  output logic              busy,
  output logic              overrun,
  output logic              rd_error
);

  localparam int unsigned CNT_W = $clog2(BURST_WORDS) + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(BURST_WORDS);
  localparam logic [11:0]       LEN_BYTES = 12'(BURST_WORDS * 4);
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(3);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA} state_e;

  state_e            state_q, state_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              req_q, req_d;
  logic [11:0]       len_q;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;
  logic              rd_error_q, rd_error_d;
  logic              beat_acc;
  logic              beat_wr;
  logic [31:0]       beat_data;

`ifdef DDR_BYTE_SWAP_EN
  // Big-endian bus words become little-endian pixel order in the FIFO.
  assign beat_data = {Bus2IP_MstRd_d[7:0], Bus2IP_MstRd_d[15:8],
                      Bus2IP_MstRd_d[23:16], Bus2IP_MstRd_d[31:24]};
`else
  assign beat_data = Bus2IP_MstRd_d;
`endif

  // Next-state, pending-slot and beat-accounting logic.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    addr_d      = addr_q;
    beat_cnt_d  = beat_cnt_q;
    overrun_d   = overrun_q;
    rd_error_d  = rd_error_q;
    beat_wr     = 1'b0;
    beat_acc    = (state_q == S_DATA) && !Bus2IP_MstRd_src_rdy_n && !fifo_full;

    case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          // Older pending request goes first; a simultaneous go takes its slot.
          state_d    = S_REQ;
          addr_d     = pend_addr_q & ADDR_MASK;
          beat_cnt_d = '0;
          pend_d     = go_fill_fifo;
          if (go_fill_fifo) pend_addr_d = ddr_addr_to_read;
        end else if (go_fill_fifo) begin
          state_d    = S_REQ;
          addr_d     = ddr_addr_to_read & ADDR_MASK;
          beat_cnt_d = '0;
        end
      end
      S_REQ: begin
        if (Bus2IP_Mst_CmdAck) state_d = S_DATA;
      end
      S_DATA: begin
        if (beat_acc) begin
          if (beat_cnt_q < FULL_CNT) begin
            beat_wr    = 1'b1;
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end else begin
            rd_error_d = 1'b1;
          end
        end
        if (Bus2IP_Mst_Cmplt) begin
          state_d = S_IDLE;
          if (Bus2IP_Mst_Error || (beat_cnt_d != FULL_CNT)) rd_error_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (go_fill_fifo && (state_q != S_IDLE)) begin
      if (!pend_q) begin
        pend_d      = 1'b1;
        pend_addr_d = ddr_addr_to_read;
      end else begin
        overrun_d = 1'b1;
      end
    end

    req_d  = (state_d == S_REQ);
    busy_d = (state_d != S_IDLE) || pend_d;
  end

  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      state_q     <= S_IDLE;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      addr_q      <= '0;
      req_q       <= 1'b0;
      len_q       <= '0;
      beat_cnt_q  <= '0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      rd_error_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      addr_q      <= addr_d;
      req_q       <= req_d;
      len_q       <= LEN_BYTES;
      beat_cnt_q  <= beat_cnt_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      rd_error_q  <= rd_error_d;
    end
  end

  assign IP2Bus_MstRd_Req       = req_q;
  assign IP2Bus_Mst_Addr        = addr_q;
  assign IP2Bus_Mst_Length      = len_q;
  assign IP2Bus_MstRd_dst_rdy_n = (state_q == S_DATA) ? fifo_full : 1'b1;
  assign fifo_wr_en             = beat_wr;
  assign fifo_wr_data           = beat_wr ? beat_data : 32'h0;
  assign busy                   = busy_q;
  assign overrun                = overrun_q;
  assign rd_error               = rd_error_q;

endmodule
